// File: rtl/card_dealer.sv
// Card dealer: deck held as 13 per-rank counts; a deal searches upward from a free-running rank counter.
// Latency 1..13 cycles from accepted deal_req to card_valid; ready is low while searching and requests are dropped.
module card_dealer #(
    parameter int CARDS_PER_RANK = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       deal_req,
    input  logic       shuffle,
    output logic       ready,
    output logic [3:0] card,
    output logic       card_valid,
    output logic [5:0] cards_left,
    output logic       deck_empty,
    output logic       empty_err
);

    localparam int CW = $clog2(CARDS_PER_RANK + 1);
    localparam logic [CW-1:0] FULL_RANK = CW'(CARDS_PER_RANK);
    localparam logic [5:0] FULL_DECK = 6'(13 * CARDS_PER_RANK);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      rng_q, rng_d;
    logic [3:0]      ptr_q, ptr_d;
    logic [CW-1:0]   count_q [13];
    logic [CW-1:0]   count_d [13];
    logic [5:0]      left_q, left_d;
    logic [3:0]      card_q, card_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [3:0]      idx;

    // ptr holds ranks 1..13; the count array is zero-based
    assign idx = ptr_q - 4'd1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        left_d  = left_q;
        card_d  = card_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        rng_d   = (rng_q == 4'd13) ? 4'd1 : rng_q + 4'd1;

        if (shuffle) begin
            for (int i = 0; i < 13; i++) begin
                count_d[i] = FULL_RANK;
            end
            left_d  = FULL_DECK;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (deal_req) begin
                        if (left_q != 6'd0) begin
                            ptr_d   = rng_q;
                            state_d = SCAN;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (count_q[idx] != '0) begin
                        count_d[idx] = count_q[idx] - CW'(1);
                        left_d       = left_q - 6'd1;
                        card_d       = ptr_q;
                        valid_d      = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        // rank exhausted: try the next one, wrapping K back to A
                        ptr_d = (ptr_q == 4'd13) ? 4'd1 : ptr_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rng_q   <= 4'd1;
            ptr_q   <= 4'd1;
            for (int i = 0; i < 13; i++) begin
                count_q[i] <= FULL_RANK;
            end
            left_q  <= FULL_DECK;
            card_q  <= 4'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rng_q   <= rng_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            left_q  <= left_d;
            card_q  <= card_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign ready      = (state_q == IDLE);
    assign card       = card_q;
    assign card_valid = valid_q;
    assign cards_left = left_q;
    assign deck_empty = (left_q == 6'd0);
    assign empty_err  = err_q;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: a rank-count deck model plus the edge count since reset predicts every dealt card and its latency.
module tb_card_dealer;

    logic       clock;
    logic       reset;
    logic       deal_req;
    logic       shuffle;
    logic       ready;
    logic [3:0] card;
    logic       card_valid;
    logic [5:0] cards_left;
    logic       deck_empty;
    logic       empty_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int edge_n = 0;
    int rst_edge = 0;

    int cnt_m [13];
    int left_m;
    int card_m;

    card_dealer #(.CARDS_PER_RANK(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .deal_req   (deal_req),
        .shuffle    (shuffle),
        .ready      (ready),
        .card       (card),
        .card_valid (card_valid),
        .cards_left (cards_left),
        .deck_empty (deck_empty),
        .empty_err  (empty_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // rank the dealer will sample at the coming edge: 1 at the first edge after reset, then +1 mod 13
    function automatic int rng_next();
        return ((edge_n - rst_edge) % 13) + 1;
    endfunction

    task automatic model_full();
        for (int i = 0; i < 13; i++) cnt_m[i] = 4;
        left_m = 52;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        rst_edge = edge_n;
        reset = 1'b0;
        model_full();
        card_m = 0;
    endtask

    // target<1 deals at the very next edge; noise toggles deal_req while searching
    task automatic do_deal(input int target, input bit noise, output int got, output int k_got);
        int r0;
        int r;
        int k;
        if (target >= 1) begin
            for (int w = 0; w < 13 && rng_next() != target; w++) tick();
        end
        r0 = rng_next();
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        if (left_m == 0) begin
            n_cmp++;
            if (empty_err !== 1'b1 || card_valid !== 1'b0 || card !== 4'(card_m)) begin
                n_fail++;
                $display("FAIL empty_deal err=%0b valid=%0b card=%0d want err=1 valid=0 card=%0d",
                         empty_err, card_valid, card, card_m);
            end
            tick();
            n_cmp++;
            if (empty_err !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_err_pulse got %0b want 0", empty_err);
            end
            got = card_m;
            k_got = 0;
            return;
        end
        r = r0;
        k = 1;
        while (cnt_m[r-1] == 0) begin
            r = (r % 13) + 1;
            k++;
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_ready got %0b want 0", ready);
        end
        got = -1;
        k_got = -1;
        for (int j = 1; j <= 14; j++) begin
            deal_req = noise ? 1'($urandom % 2) : 1'b0;
            tick();
            if (card_valid === 1'b1) begin
                got = card;
                k_got = j;
                break;
            end
        end
        deal_req = 1'b0;
        cnt_m[r-1]--;
        left_m--;
        card_m = r;
        n_cmp++;
        if (k_got !== k || got !== r) begin
            n_fail++;
            $display("FAIL deal_result rng=%0d got card=%0d k=%0d want card=%0d k=%0d", r0, got, k_got, r, k);
        end
        n_cmp++;
        if (cards_left !== 6'(left_m) || ready !== 1'b1 || empty_err !== 1'b0 ||
            deck_empty !== (left_m == 0)) begin
            n_fail++;
            $display("FAIL deal_status left=%0d ready=%0b err=%0b empty=%0b want left=%0d ready=1 err=0 empty=%0b",
                     cards_left, ready, empty_err, deck_empty, left_m, left_m == 0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if (ready !== 1'b1 || deck_empty !== 1'b0 || cards_left !== 6'd52 || card !== 4'd0 ||
            card_valid !== 1'b0 || empty_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready=%0b empty=%0b left=%0d card=%0d valid=%0b err=%0b want 1,0,52,0,0,0",
                     tag, ready, deck_empty, cards_left, card, card_valid, empty_err);
        end
    endtask

    task automatic test_reset();
        int got, k;
        do_reset();
        check_reset_values("reset_values");
        do_deal(3, 1'b0, got, k);
        n_cmp++;
        if (got !== 3 || k !== 1 || cards_left !== 6'd51) begin
            n_fail++;
            $display("FAIL first_deal card=%0d k=%0d left=%0d want 3 1 51", got, k, cards_left);
        end
        tick();
        n_cmp++;
        if (card_valid !== 1'b0 || card !== 4'd3) begin
            n_fail++;
            $display("FAIL valid_pulse valid=%0b card=%0d want 0 3", card_valid, card);
        end
    endtask

    task automatic test_rank5();
        int got, k;
        int want [5] = '{5, 5, 5, 5, 6};
        do_reset();
        for (int d = 0; d < 5; d++) begin
            do_deal(5, 1'b0, got, k);
            n_cmp++;
            if (got !== want[d] || k !== ((d == 4) ? 2 : 1)) begin
                n_fail++;
                $display("FAIL rank5_deal%0d card=%0d k=%0d want %0d %0d", d, got, k, want[d], (d == 4) ? 2 : 1);
            end
        end
        n_cmp++;
        if (cards_left !== 6'd47 || cnt_m[4] !== 0) begin
            n_fail++;
            $display("FAIL rank5_left got %0d want 47", cards_left);
        end
    endtask

    task automatic test_drain();
        int got, k;
        int last;
        do_reset();
        for (int d = 0; d < 52; d++) do_deal(-1, 1'b0, got, k);
        n_cmp++;
        if (deck_empty !== 1'b1 || cards_left !== 6'd0) begin
            n_fail++;
            $display("FAIL drain_empty empty=%0b left=%0d want 1 0", deck_empty, cards_left);
        end
        last = card_m;
        do_deal(-1, 1'b0, got, k);
        n_cmp++;
        if (card !== 4'(last) || card_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL deal53 card=%0d valid=%0b want %0d 0", card, card_valid, last);
        end
    endtask

    task automatic test_shuffle_with_deal();
        int last;
        last = card_m;
        shuffle = 1'b1;
        deal_req = 1'b1;
        tick();
        shuffle = 1'b0;
        deal_req = 1'b0;
        model_full();
        n_cmp++;
        if (cards_left !== 6'd52 || deck_empty !== 1'b0 || card_valid !== 1'b0 ||
            empty_err !== 1'b0 || ready !== 1'b1 || card !== 4'(last)) begin
            n_fail++;
            $display("FAIL shuffle_deal left=%0d empty=%0b valid=%0b err=%0b ready=%0b card=%0d want 52 0 0 0 1 %0d",
                     cards_left, deck_empty, card_valid, empty_err, ready, card, last);
        end
        tick();
        n_cmp++;
        if (card_valid !== 1'b0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL shuffle_deal_after valid=%0b ready=%0b want 0 1", card_valid, ready);
        end
    endtask

    task automatic drain_low_ranks();
        int got, k;
        for (int d = 0; d < 48; d++) do_deal(1, 1'b0, got, k);
        for (int w = 0; w < 13 && rng_next() != 1; w++) tick();
        deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
        for (int j = 0; j < 3; j++) tick();
    endtask

    task automatic test_shuffle_mid_scan();
        int seen;
        do_reset();
        drain_low_ranks();
        shuffle = 1'b1;
        tick();
        shuffle = 1'b0;
        model_full();
        n_cmp++;
        if (ready !== 1'b1 || cards_left !== 6'd52 || card_valid !== 1'b0 || card !== 4'd12) begin
            n_fail++;
            $display("FAIL shuffle_scan ready=%0b left=%0d valid=%0b card=%0d want 1 52 0 12",
                     ready, cards_left, card_valid, card);
        end
        seen = 0;
        for (int j = 0; j < 14; j++) begin
            tick();
            if (card_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL shuffle_scan_late_valid got %0d pulses want 0", seen);
        end
    endtask

    task automatic test_reset_mid_scan();
        int got, k, seen;
        do_reset();
        drain_low_ranks();
        do_reset();
        check_reset_values("reset_mid_scan");
        seen = 0;
        do_deal(-1, 1'b0, got, k);
        n_cmp++;
        if (got !== 1 || k !== 1) begin
            n_fail++;
            $display("FAIL reset_rng card=%0d k=%0d want 1 1", got, k);
        end
    endtask

    task automatic test_back_to_back();
        int got, k;
        do_reset();
        for (int it = 0; it < 70; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                shuffle = 1'b1;
                deal_req = 1'($urandom % 2);
                tick();
                shuffle = 1'b0;
                deal_req = 1'b0;
                model_full();
                n_cmp++;
                if (cards_left !== 6'd52 || card_valid !== 1'b0 || empty_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_shuffle left=%0d valid=%0b err=%0b want 52 0 0", cards_left, card_valid, empty_err);
                end
            end else begin
                do_deal(($urandom % 3 == 0) ? -1 : int'($urandom_range(1, 13)), 1'b1, got, k);
            end
        end
    endtask

    always @(negedge clock) begin
        if (card_valid === 1'b1 && empty_err === 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL valid_and_err both high at edge %0d", edge_n);
        end
    end

    initial begin
        reset = 1'b1;
        deal_req = 1'b0;
        shuffle = 1'b0;
        tick();
        test_reset();
        test_rank5();
        test_drain();
        test_shuffle_with_deal();
        test_shuffle_mid_scan();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
CARD_DEALER -- requirements
Module: card_dealer

Interface
REQ-001 Parameter CARDS_PER_RANK, default 4, copies of each rank (1..13) in a full deck; deck size = 13*CARDS_PER_RANK.
REQ-002 Port clock  in  1  single clock; all state SHALL update on rising edge only.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Port deal_req  in  1  request one card; sampled each edge; accepted only while ready=1.
REQ-005 Port shuffle  in  1  restore full deck; sampled each edge.
REQ-006 Port ready  out  1  high in IDLE, low in SCAN.
REQ-007 Port card  out  4  last dealt rank (1=A .. 10, 11=J, 12=Q, 13=K); held until next deal.
REQ-008 Port card_valid  out  1  one-cycle pulse when card is updated.
REQ-009 Port cards_left  out  6  cards remaining in deck.
REQ-010 Port deck_empty  out  1  high when cards_left==0.
REQ-011 Port empty_err  out  1  one-cycle pulse on deal_req accepted with empty deck.

Function
REQ-012 Deck SHALL be held as 13 per-rank remaining counts, each 0..CARDS_PER_RANK; no card array.
REQ-013 Free-running rank counter rng SHALL step 1,2,..,13,1,.. every cycle; unaffected by shuffle or deal activity.
REQ-014 FSM states SHALL be IDLE and SCAN only.
REQ-015 IDLE, deal_req=1, shuffle=0, cards_left>0: ptr <= rng, go SCAN.
REQ-016 SCAN, count[ptr]!=0: count[ptr] decremented, cards_left decremented, card <= ptr, card_valid=1 next cycle, go IDLE.
REQ-017 SCAN, count[ptr]==0: ptr <= ptr+1 with 13 wrapping to 1, stay SCAN.
REQ-018 Latency: deal_req sampled at edge E0; card_valid SHALL be high in the cycle after edge E0+k, where k=1..13 is the number of ranks examined; k<=13 is guaranteed because cards_left>0.
REQ-019 IDLE, deal_req=1, cards_left==0: empty_err pulses for one cycle; card, counts and state unchanged; card_valid stays 0.
REQ-020 deal_req while in SCAN SHALL be ignored; it is not queued.
REQ-021 shuffle=1 in any state SHALL set all counts to CARDS_PER_RANK and cards_left to 52, and force IDLE; an in-flight SCAN is aborted with no card_valid; card is unchanged.
REQ-022 shuffle and deal_req in the same cycle: shuffle wins and deal_req is dropped.
REQ-023 deck_empty SHALL be combinational from cards_left==0.
REQ-024 card_valid and empty_err SHALL never be high in the same cycle.

Reset
REQ-025 reset=1 at an edge SHALL set: state IDLE, all counts CARDS_PER_RANK, cards_left=52, card=0, card_valid=0, empty_err=0, rng=1.
REQ-026 Outputs after reset: ready=1, deck_empty=0.
REQ-027 reset SHALL override shuffle and deal_req; reset mid-SCAN aborts it with no card_valid.

Verification
REQ-028 Apply reset, release it, then assert deal_req for 1 cycle when rng=3 -> card=3, card_valid 1 cycle after edge E0+1, cards_left=51.
REQ-029 Issue 5 deals each sampled at rng=5 -> cards 5,5,5,5,6; rank-5 count=0; fifth deal has k=2; cards_left=47.
REQ-030 Issue 52 deals -> deck_empty=1, cards_left=0; issue a 53rd deal_req -> empty_err 1 pulse, card_valid=0, card unchanged.
REQ-031 Empty deck, assert shuffle together with deal_req -> cards_left=52, deck_empty=0, no card_valid, no empty_err.
REQ-032 Drain ranks 1..12, deal at rng=1, pulse shuffle during SCAN -> no card_valid, IDLE next cycle, cards_left=52.
REQ-033 Assert reset during SCAN -> no card_valid; all REQ-025 values hold on the next cycle.
